axi4_lite_slave: RTL and testbench
==================================

# axi4_lite_slave

AXI4-Lite responder that terminates a single master port and exposes a bank of 32-bit read/write control registers. It accepts write address and write data independently, in either order or together, and applies byte strobes. It returns write responses and read data with full valid/ready backpressure. It sits opposite the codebase's AXI4-Lite master and drives peripheral configuration through a flat register output.

## Interface
- NUM_REGS, 16, number of 32-bit registers; power of two, 2..256; IDX_W = log2(NUM_REGS)
- BASE_ADDR, 32'h0000_0000, byte base address; aligned to NUM_REGS*4
- iCLK  in  1  clock, all logic on rising edge
- iRST  in  1  asynchronous, active-low reset
- s_AWVALID in 1 / s_AWREADY out 1 / s_AWADDR in 32 / s_AWPROT in 3: write address channel
- s_WVALID in 1 / s_WREADY out 1 / s_WDATA in 32 / s_WSTRB in 4: write data channel
- s_BVALID out 1 / s_BREADY in 1 / s_BRESP out 2: write response channel
- s_ARVALID in 1 / s_ARREADY out 1 / s_ARADDR in 32 / s_ARPROT in 3: read address channel
- s_RVALID out 1 / s_RREADY in 1 / s_RDATA out 32 / s_RRESP out 2: read data channel
- oREGS  out  NUM_REGS*32  register contents; reg k at bits [32k+31:32k]

## Operation
- Reset, asynchronous on iRST low: all registers 0, s_BVALID 0, s_RVALID 0, s_BRESP 0, s_RRESP 0, s_RDATA 0, address/data holding flags cleared.
- s_AWPROT and s_ARPROT are accepted and ignored.
- Decode: index = ADDR[IDX_W+1:2]. In range iff ADDR[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]. ADDR[1:0] are ignored.
- Write path: separate holding registers for the address (aw_held) and data+strobe (w_held).
  - s_AWREADY = !aw_held && !s_BVALID.
  - s_WREADY = !w_held && !s_BVALID.
  - Both readies are combinational from registered state and are 1 right after reset.
  - Commit happens at the edge where an address and data are both available, each either held or handshaking that cycle.
  - On commit: byte lane i of the register is written iff s_WSTRB[i]; s_BVALID is set; both held flags are cleared.
  - Otherwise, a lone handshake sets its held flag and captures its payload.
  - s_BVALID stays 1, with s_BRESP stable, until s_BVALID && s_BREADY; it then clears on that edge.
- Read path: s_ARREADY = !s_RVALID.
  - On AR handshake, s_RDATA is registered with the addressed register, and s_RVALID and s_RRESP are set.
  - s_RDATA and s_RRESP are held stable until s_RVALID && s_RREADY.
- Simultaneous read and write to the same register at the same edge: the read returns the pre-write value.
- WSTRB = 0: a legal write that changes nothing; BRESP as for any write.
- oREGS reflects register state directly, updated on the commit edge.

## Timing
- AW and W handshake together at edge N: register updated and s_BVALID = 1 after edge N.
- AW at edge N, W at edge N+k: commit at edge N+k. s_AWREADY is low during cycles N+1..N+k; s_WREADY remains high until the W handshake.
- With s_BREADY held 1: s_BVALID is high for exactly one cycle. The next write can be accepted the cycle after it clears, giving a maximum rate of one write every 2 cycles.
- AR handshake at edge N: s_RVALID = 1 after edge N. With s_RREADY = 1 it clears at N+1, giving a maximum rate of one read every 2 cycles.
- Read and write paths are fully independent and may complete on the same edge.
- Reset asserted mid-transaction: all in-flight state is discarded immediately and no response is issued.

## Configuration
- AXI4_LITE_SLAVE_SLVERR_EN defined:
  - An out-of-range write updates nothing and returns BRESP = 2'b10 (SLVERR).
  - An out-of-range read returns RDATA = 0 and RRESP = 2'b10.
  - In-range accesses return 2'b00.
- Not defined:
  - Out-of-range writes are dropped silently; out-of-range reads return 0.
  - All responses are OKAY (2'b00) and s_BRESP/s_RRESP are tied 0.

## Test plan
- Reset, then write 32'hDEADBEEF to 0x04 with WSTRB = 4'hF, AW and W in the same cycle -> s_BVALID after 1 cycle, BRESP 0, oREGS[63:32] = DEADBEEF; read 0x04 -> RDATA DEADBEEF, RRESP 0.
- Write W three cycles before AW: data 32'h11223344, addr 0x08 -> s_WREADY low while held; commit on the AW edge; reg2 = 11223344.
- Partial strobe: reg2 = 11223344, write 32'hAABBCCDD with WSTRB = 4'b0101 -> reg2 = 11BB33DD.
- Backpressure: hold s_BREADY and s_RREADY low for 5 cycles -> s_BVALID, s_RVALID, s_RDATA, s_BRESP stable; s_AWREADY, s_WREADY, s_ARREADY low; all clear 1 edge after the readies rise.
- Same-edge read and write to 0x00: old 0, new 32'h5A5A5A5A -> RDATA 0; a subsequent read returns 5A5A5A5A.
- Out-of-range address 0x40 (NUM_REGS = 16) -> with the macro: BRESP/RRESP 2'b10, RDATA 0, no register changed; without it: responses 2'b00, no register changed.

Source files
------------

// File: rtl/axi4_lite_slave.sv
// rtl/axi4_lite_slave.sv - AXI4-Lite register bank responder with byte strobes and independent AW/W acceptance
// Optional AXI4_LITE_SLAVE_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axi4_lite_slave #(
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     s_AWVALID,
  output logic                     s_AWREADY,
  input  logic [31:0]              s_AWADDR,
  input  logic [2:0]               s_AWPROT,
  input  logic                     s_WVALID,
  output logic                     s_WREADY,
  input  logic [31:0]              s_WDATA,
  input  logic [3:0]               s_WSTRB,
  output logic                     s_BVALID,
  input  logic                     s_BREADY,
  output logic [1:0]               s_BRESP,
  input  logic                     s_ARVALID,
  output logic                     s_ARREADY,
  input  logic [31:0]              s_ARADDR,
  input  logic [2:0]               s_ARPROT,
  output logic                     s_RVALID,
  input  logic                     s_RREADY,
  output logic [31:0]              s_RDATA,
  output logic [1:0]               s_RRESP,
  output logic [NUM_REGS*32-1:0]   oREGS
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [31:0] regs [NUM_REGS];

  logic        aw_held;
  logic [31:0] aw_addr_q;
  logic        w_held;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        bvalid_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;

  logic             aw_hs;
  logic             w_hs;
  logic             commit;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic [3:0]       wr_strb;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_in_range;
  logic             ar_hs;
  logic [IDX_W-1:0] ar_idx;
  logic             ar_in_range;

  assign s_AWREADY = !aw_held && !bvalid_q;
  assign s_WREADY  = !w_held && !bvalid_q;
  assign s_ARREADY = !rvalid_q;
  assign s_BVALID  = bvalid_q;
  assign s_RVALID  = rvalid_q;
  assign s_RDATA   = rdata_q;

  assign aw_hs = s_AWVALID && s_AWREADY;
  assign w_hs  = s_WVALID && s_WREADY;

  // Each half of a write is available either from its holding register or from a live handshake.
  assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_addr = aw_held ? aw_addr_q : s_AWADDR;
  assign wr_data = w_held ? w_data_q : s_WDATA;
  assign wr_strb = w_held ? w_strb_q : s_WSTRB;

  assign wr_idx      = wr_addr[IDX_W+1:2];
  assign wr_in_range = (wr_addr[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]);

  assign ar_hs       = s_ARVALID && s_ARREADY;
  assign ar_idx      = s_ARADDR[IDX_W+1:2];
  assign ar_in_range = (s_ARADDR[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]);

  logic unused;
  assign unused = ^{s_AWPROT, s_ARPROT, wr_addr[1:0], s_ARADDR[1:0]};

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      aw_held   <= 1'b0;
      aw_addr_q <= '0;
      w_held    <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs[k] <= '0;
      end
    end else begin
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        if (wr_in_range) begin
          for (int i = 0; i < 4; i++) begin
            if (wr_strb[i]) begin
              regs[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
          end
        end
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= s_AWADDR;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= s_WDATA;
          w_strb_q <= s_WSTRB;
        end
        if (bvalid_q && s_BREADY) begin
          bvalid_q <= 1'b0;
        end
      end
    end
  end

  // Reads sample the pre-edge register value, so a same-edge write is not visible yet.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= ar_in_range ? regs[ar_idx] : 32'h0;
    end else if (rvalid_q && s_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

`ifdef AXI4_LITE_SLAVE_SLVERR_EN
  logic [1:0] bresp_q;
  logic [1:0] rresp_q;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      bresp_q <= 2'b00;
      rresp_q <= 2'b00;
    end else begin
      if (commit) begin
        bresp_q <= wr_in_range ? 2'b00 : 2'b10;
      end
      if (ar_hs) begin
        rresp_q <= ar_in_range ? 2'b00 : 2'b10;
      end
    end
  end

  assign s_BRESP = bresp_q;
  assign s_RRESP = rresp_q;
`else
  assign s_BRESP = 2'b00;
  assign s_RRESP = 2'b00;
`endif

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign oREGS[32*k +: 32] = regs[k];
  end

endmodule

// File: tb/tb_axi4_lite_slave.sv
// tb/tb_axi4_lite_slave.sv - directed, table-driven bench for axi4_lite_slave
module tb_axi4_lite_slave;

  localparam int NUM_REGS = 16;
`ifdef AXI4_LITE_SLAVE_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic                   iCLK = 1'b0;
  logic                   iRST = 1'b0;
  logic                   s_AWVALID = 1'b0;
  logic                   s_AWREADY;
  logic [31:0]            s_AWADDR = '0;
  logic [2:0]             s_AWPROT = '0;
  logic                   s_WVALID = 1'b0;
  logic                   s_WREADY;
  logic [31:0]            s_WDATA = '0;
  logic [3:0]             s_WSTRB = '0;
  logic                   s_BVALID;
  logic                   s_BREADY = 1'b1;
  logic [1:0]             s_BRESP;
  logic                   s_ARVALID = 1'b0;
  logic                   s_ARREADY;
  logic [31:0]            s_ARADDR = '0;
  logic [2:0]             s_ARPROT = '0;
  logic                   s_RVALID;
  logic                   s_RREADY = 1'b1;
  logic [31:0]            s_RDATA;
  logic [1:0]             s_RRESP;
  logic [NUM_REGS*32-1:0] oREGS;

  int n_cmp = 0;
  int n_err = 0;

  axi4_lite_slave #(.NUM_REGS(NUM_REGS), .BASE_ADDR(32'h0)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY), .s_AWADDR(s_AWADDR), .s_AWPROT(s_AWPROT),
    .s_WVALID(s_WVALID), .s_WREADY(s_WREADY), .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB),
    .s_BVALID(s_BVALID), .s_BREADY(s_BREADY), .s_BRESP(s_BRESP),
    .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY), .s_ARADDR(s_ARADDR), .s_ARPROT(s_ARPROT),
    .s_RVALID(s_RVALID), .s_RREADY(s_RREADY), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP),
    .oREGS(oREGS)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          chk_idx;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] reg_at(input int idx);
    return oREGS[32*idx +: 32];
  endfunction

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_fire;
    bit w_fire;
    int n = 0;
    s_AWADDR = addr; s_WDATA = data; s_WSTRB = strb;
    s_AWVALID = 1'b1; s_WVALID = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_fire = s_AWVALID && s_AWREADY;
      w_fire  = s_WVALID && s_WREADY;
      tick();
      if (aw_fire) begin aw_done = 1; s_AWVALID = 1'b0; end
      if (w_fire)  begin w_done = 1;  s_WVALID = 1'b0; end
      n++;
    end
    s_AWVALID = 1'b0; s_WVALID = 1'b0;
    n = 0;
    while (!s_BVALID && n < 20) begin
      tick();
      n++;
    end
    check("write_bvalid_seen", {31'b0, s_BVALID}, 32'd1);
    resp = s_BRESP;
    tick();
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit fired = 0;
    bit ar_fire;
    int n = 0;
    s_ARADDR = addr;
    s_ARVALID = 1'b1;
    while (!fired && n < 20) begin
      ar_fire = s_ARVALID && s_ARREADY;
      tick();
      if (ar_fire) begin fired = 1; s_ARVALID = 1'b0; end
      n++;
    end
    s_ARVALID = 1'b0;
    check("read_rvalid_after_ar", {31'b0, s_RVALID}, 32'd1);
    data = s_RDATA;
    resp = s_RRESP;
    tick();
  endtask

  logic [31:0] rd;
  logic [1:0]  rsp;

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0004, 32'hDEADBEEF, 4'hF, 1,  32'hDEADBEEF, 2'b00};
    vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,        4'h0, 0,  32'hDEADBEEF, 2'b00};
    vecs[2]  = '{1'b1, 32'h0000_000C, 32'h12345678, 4'hF, 3,  32'h12345678, 2'b00};
    vecs[3]  = '{1'b1, 32'h0000_000C, 32'hAABBCCDD, 4'h5, 3,  32'h12BB56DD, 2'b00};
    vecs[4]  = '{1'b1, 32'h0000_000C, 32'hFFFFFFFF, 4'h0, 3,  32'h12BB56DD, 2'b00};
    vecs[5]  = '{1'b0, 32'h0000_000E, 32'h0,        4'h0, 0,  32'h12BB56DD, 2'b00};
    vecs[6]  = '{1'b1, 32'h0000_003C, 32'hCAFEF00D, 4'hF, 15, 32'hCAFEF00D, 2'b00};
    vecs[7]  = '{1'b0, 32'h0000_003C, 32'h0,        4'h0, 0,  32'hCAFEF00D, 2'b00};
    vecs[8]  = '{1'b1, 32'h0000_0040, 32'hFFFFFFFF, 4'hF, 0,  32'h00000000, ERR};
    vecs[9]  = '{1'b0, 32'h0000_0040, 32'h0,        4'h0, 0,  32'h00000000, ERR};
    vecs[10] = '{1'b0, 32'h1000_0004, 32'h0,        4'h0, 0,  32'h00000000, ERR};

    tick(); tick();
    check("rst_bvalid",  {31'b0, s_BVALID},  32'd0);
    check("rst_rvalid",  {31'b0, s_RVALID},  32'd0);
    check("rst_awready", {31'b0, s_AWREADY}, 32'd1);
    check("rst_wready",  {31'b0, s_WREADY},  32'd1);
    check("rst_arready", {31'b0, s_ARREADY}, 32'd1);
    check("rst_rdata",   s_RDATA, 32'h0);
    check("rst_regs_or", {31'b0, |oREGS}, 32'd0);
    iRST = 1'b1;
    tick();

    // Same-cycle AW+W: BVALID must be visible right after the handshake edge.
    s_AWADDR = 32'h4; s_WDATA = 32'hDEADBEEF; s_WSTRB = 4'hF;
    s_AWVALID = 1'b1; s_WVALID = 1'b1;
    tick();
    s_AWVALID = 1'b0; s_WVALID = 1'b0;
    check("first_bvalid_1cyc", {31'b0, s_BVALID}, 32'd1);
    check("first_bresp", {30'b0, s_BRESP}, 32'd0);
    check("first_reg1", reg_at(1), 32'hDEADBEEF);
    tick();
    check("first_bvalid_clr", {31'b0, s_BVALID}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rsp);
        check($sformatf("vec%0d_wreg", i), reg_at(vecs[i].chk_idx), vecs[i].exp_data);
        check($sformatf("vec%0d_bresp", i), {30'b0, rsp}, {30'b0, vecs[i].exp_resp});
      end else begin
        axi_read(vecs[i].addr, rd, rsp);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
        check($sformatf("vec%0d_rresp", i), {30'b0, rsp}, {30'b0, vecs[i].exp_resp});
      end
    end
    check("oor_reg1_kept", reg_at(1), 32'hDEADBEEF);

    // W three cycles ahead of AW.
    s_WDATA = 32'h11223344; s_WSTRB = 4'hF; s_WVALID = 1'b1;
    tick();
    s_WVALID = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("wfirst_wready_low", {31'b0, s_WREADY}, 32'd0);
      check("wfirst_awready_hi", {31'b0, s_AWREADY}, 32'd1);
      check("wfirst_no_bvalid", {31'b0, s_BVALID}, 32'd0);
      if (c < 2) tick();
    end
    s_AWADDR = 32'h8; s_AWVALID = 1'b1;
    tick();
    s_AWVALID = 1'b0;
    check("wfirst_bvalid", {31'b0, s_BVALID}, 32'd1);
    check("wfirst_reg2", reg_at(2), 32'h11223344);
    tick();
    axi_write(32'h8, 32'hAABBCCDD, 4'b0101, rsp);
    check("pstrb_reg2", reg_at(2), 32'h11BB33DD);

    // AW two cycles ahead of W.
    s_AWADDR = 32'h14; s_AWVALID = 1'b1;
    tick();
    s_AWVALID = 1'b0;
    for (int c = 0; c < 2; c++) begin
      check("awfirst_awready_low", {31'b0, s_AWREADY}, 32'd0);
      check("awfirst_wready_hi", {31'b0, s_WREADY}, 32'd1);
      tick();
    end
    s_WDATA = 32'h0BADF00D; s_WSTRB = 4'hF; s_WVALID = 1'b1;
    tick();
    s_WVALID = 1'b0;
    check("awfirst_bvalid", {31'b0, s_BVALID}, 32'd1);
    check("awfirst_reg5", reg_at(5), 32'h0BADF00D);
    tick();

    // Backpressure on both response channels.
    s_BREADY = 1'b0; s_RREADY = 1'b0;
    s_AWADDR = 32'h10; s_WDATA = 32'h0000BEEF; s_WSTRB = 4'hF; s_ARADDR = 32'h4;
    s_AWVALID = 1'b1; s_WVALID = 1'b1; s_ARVALID = 1'b1;
    tick();
    s_AWVALID = 1'b0; s_WVALID = 1'b0; s_ARVALID = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("bp_bvalid", {31'b0, s_BVALID}, 32'd1);
      check("bp_rvalid", {31'b0, s_RVALID}, 32'd1);
      check("bp_rdata", s_RDATA, 32'hDEADBEEF);
      check("bp_bresp", {30'b0, s_BRESP}, 32'd0);
      check("bp_readies", {29'b0, s_AWREADY, s_WREADY, s_ARREADY}, 32'd0);
      tick();
    end
    s_BREADY = 1'b1; s_RREADY = 1'b1;
    tick();
    check("bp_bvalid_clr", {31'b0, s_BVALID}, 32'd0);
    check("bp_rvalid_clr", {31'b0, s_RVALID}, 32'd0);
    check("bp_readies_back", {29'b0, s_AWREADY, s_WREADY, s_ARREADY}, 32'd7);
    check("bp_reg4", reg_at(4), 32'h0000BEEF);

    // Same-edge read and write of register 0.
    s_AWADDR = 32'h0; s_WDATA = 32'h5A5A5A5A; s_WSTRB = 4'hF; s_ARADDR = 32'h0;
    s_AWVALID = 1'b1; s_WVALID = 1'b1; s_ARVALID = 1'b1;
    tick();
    s_AWVALID = 1'b0; s_WVALID = 1'b0; s_ARVALID = 1'b0;
    check("rw_same_rdata_old", s_RDATA, 32'h0);
    check("rw_same_reg0_new", reg_at(0), 32'h5A5A5A5A);
    tick();
    axi_read(32'h0, rd, rsp);
    check("rw_same_reread", rd, 32'h5A5A5A5A);

    // Reset while a write half is held.
    s_WDATA = 32'hFFFF0000; s_WSTRB = 4'hF; s_WVALID = 1'b1;
    tick();
    s_WVALID = 1'b0;
    iRST = 1'b0;
    #1;
    check("midrst_regs_or", {31'b0, |oREGS}, 32'd0);
    check("midrst_wready", {31'b0, s_WREADY}, 32'd1);
    check("midrst_bvalid", {31'b0, s_BVALID}, 32'd0);
    tick();
    iRST = 1'b1;
    tick();
    s_AWADDR = 32'h0; s_AWVALID = 1'b1;
    tick();
    s_AWVALID = 1'b0;
    check("postrst_no_commit", {31'b0, s_BVALID}, 32'd0);
    check("postrst_awready_low", {31'b0, s_AWREADY}, 32'd0);
    s_WDATA = 32'h00000077; s_WSTRB = 4'hF; s_WVALID = 1'b1;
    tick();
    s_WVALID = 1'b0;
    check("postrst_bvalid", {31'b0, s_BVALID}, 32'd1);
    check("postrst_reg0", reg_at(0), 32'h00000077);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
